hamming_enc_engine: RTL

Memory-walking SECDED (Hamming (16,11) plus overall parity) encoder. It sits directly upstream of the program-2 decoder stage. On `start` it reads 11-bit messages from data memory and computes parity. It writes 16-bit codewords back to data memory in the exact layout the decoder consumes. It shares the single-port data memory with the core and owns the port only while busy.

---
 rtl/hamming_enc_engine_if.sv | 22 ++
 rtl/hamming_enc_engine.sv | 111 +++++++++++
 2 files changed

// File: rtl/hamming_enc_engine_if.sv
// rtl/hamming_enc_engine_if.sv - start/status handshake and data-memory port of the SECDED encoder
interface hamming_enc_engine_if #(
    parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;

  modport master (
    input  start, mem_rd_data,
    output busy, done, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    output start, mem_rd_data,
    input  busy, done, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/hamming_enc_engine.sv
// rtl/hamming_enc_engine.sv - memory-walking Hamming(16,11)+overall-parity encoder
module hamming_enc_engine #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    hamming_enc_engine_if.master bus
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_WR_LO = 3'd4;
  localparam logic [2:0] S_WR_HI = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  logic [2:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        d_lo;
  logic [15:0]       cw;
  logic [ADDR_W-1:0] word_off;
  logic [ADDR_W-1:0] src_lo_addr;
  logic [ADDR_W-1:0] dst_lo_addr;

  // d[k] sits at bit k of the argument; bit 0 is unused padding so indices match the formulas.
  function automatic logic [15:0] encode(input logic [11:0] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      d_lo  <= '0;
      cw    <= '0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (bus.start) begin
            state <= S_RD_LO;
            idx   <= '0;
          end
        end
        S_RD_LO: state <= S_RD_HI;
        S_RD_HI: begin
          d_lo  <= bus.mem_rd_data;
          state <= S_CAP;
        end
        S_CAP: begin
          cw    <= encode({bus.mem_rd_data[2:0], d_lo, 1'b0});
          state <= S_WR_LO;
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: begin
          if (idx == LAST_IDX) begin
            state <= S_FIN;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_RD_LO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign word_off    = ADDR_W'({idx, 1'b0});
  assign src_lo_addr = SRC_A + word_off;
  assign dst_lo_addr = DST_A + word_off;

  // Memory port is decoded from registered state only, so reset drops the strobe immediately.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state)
      S_RD_LO: bus.mem_addr = src_lo_addr;
      S_RD_HI: bus.mem_addr = src_lo_addr + ONE_A;
      S_WR_LO: begin
        bus.mem_addr    = dst_lo_addr;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cw[7:0];
      end
      S_WR_HI: begin
        bus.mem_addr    = dst_lo_addr + ONE_A;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cw[15:8];
      end
      default: ;
    endcase
  end

  assign bus.busy = (state != S_IDLE) && (state != S_FIN);
  assign bus.done = (state == S_FIN);
endmodule
